// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch hazard stall controller with counter-driven multi-cycle stalls.
// Optional macro HAZARD_PERF_CNT_EN adds saturating load/branch stall-cycle counters.
module hazard_stall_ctrl #(
  parameter int         REG_ADDR_W          = 5,
  parameter int         INSTR_W             = 32,
  parameter int         LOAD_STALL_CYCLES   = 1,
  parameter int         BRANCH_STALL_CYCLES = 2,
  parameter logic [5:0] OPC_BEQ             = 6'b000100,
  parameter logic [5:0] OPC_BNE             = 6'b000101
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic [INSTR_W-1:0]    if_id_instr,
  input  logic                  flush,
  output logic                  hold_pc,
  output logic                  hold_if_id,
  output logic                  bubble_sel,
  output logic [1:0]            stall_type,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]           load_stall_cnt,
  output logic [31:0]           branch_stall_cnt,
`endif
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_BRANCH = 2'b10
  } state_e;

  localparam logic [2:0] LOAD_INIT   = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] BRANCH_INIT = 3'(BRANCH_STALL_CYCLES - 1);
  localparam int         RS_HI       = INSTR_W - 7;
  localparam int         RT_HI       = RS_HI - REG_ADDR_W;

  state_e                state_q;
  logic [2:0]            cnt_q;
  logic                  br_sup_q;

  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic                  ld_haz;
  logic                  br_haz;
  logic [1:0]            stall_type_d;
  logic                  unused_instr_bits;

  assign opcode = if_id_instr[INSTR_W-1 -: 6];
  assign rs     = if_id_instr[RS_HI -: REG_ADDR_W];
  assign rt     = if_id_instr[RT_HI -: REG_ADDR_W];
  assign unused_instr_bits = ^if_id_instr[RT_HI-REG_ADDR_W:0];

  // Register 0 is hardwired, so a load targeting it can never feed a consumer.
  assign ld_haz = id_ex_mem_read && (id_ex_rt != '0) &&
                  ((id_ex_rt == rs) || (id_ex_rt == rt));
  assign br_haz = ((opcode == OPC_BEQ) || (opcode == OPC_BNE)) && !br_sup_q;

  // In IDLE the stall type comes straight from the decode; inside a stall the state owns it.
  always_comb begin
    stall_type_d = 2'b00;
    if (flush) begin
      stall_type_d = 2'b00;
    end else begin
      case (state_q)
        ST_LOAD:   stall_type_d = 2'b01;
        ST_BRANCH: stall_type_d = 2'b10;
        default: begin
          if (ld_haz)      stall_type_d = 2'b01;
          else if (br_haz) stall_type_d = 2'b10;
        end
      endcase
    end
  end

  assign stall_type = stall_type_d;
  assign hold_pc    = (stall_type_d != 2'b00);
  assign hold_if_id = (stall_type_d != 2'b00);
  assign bubble_sel = (stall_type_d != 2'b00);
  assign dbg_state  = state_q;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      br_sup_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ld_haz) begin
            if (LOAD_STALL_CYCLES > 1) begin
              state_q <= ST_LOAD;
              cnt_q   <= LOAD_INIT;
            end
          end else if (br_haz) begin
            if (BRANCH_STALL_CYCLES > 1) begin
              state_q <= ST_BRANCH;
              cnt_q   <= BRANCH_INIT;
            end else begin
              br_sup_q <= 1'b1;
            end
          end else begin
            // No hold this cycle: IF/ID advances, so the suppressed branch has left.
            br_sup_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_q <= ST_IDLE;
        end
        ST_BRANCH: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q  <= ST_IDLE;
            br_sup_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      load_stall_cnt   <= 32'd0;
      branch_stall_cnt <= 32'd0;
    end else begin
      if ((stall_type_d == 2'b01) && (load_stall_cnt != 32'hFFFF_FFFF))
        load_stall_cnt <= load_stall_cnt + 32'd1;
      if ((stall_type_d == 2'b10) && (branch_stall_cnt != 32'hFFFF_FFFF))
        branch_stall_cnt <= branch_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a default instance (load 1, branch 2) and a
// long-stall instance (load 4, branch 3) share stimulus; expectations go through a queue.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rt;
  logic [31:0] if_id_instr;
  logic        flush;

  logic       a_hold_pc, a_hold_if_id, a_bubble;
  logic [1:0] a_stype, a_dbg;
  logic       b_hold_pc, b_hold_if_id, b_bubble;
  logic [1:0] b_stype, b_dbg;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_ld_cnt, a_br_cnt, b_ld_cnt, b_br_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int step_no = 0;
  int exp_a_ld = 0, exp_a_br = 0, exp_b_ld = 0, exp_b_br = 0;
  logic [9:0] exp_q[$];

  // {hold_pc, hold_if_id, bubble_sel, stall_type}
  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] LD = 5'b11101;
  localparam logic [4:0] BR = 5'b11110;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] ADD_RS8  = {6'd0, 5'd8, 5'd10, 5'd9, 11'h020};
  localparam logic [31:0] ADD_NOM  = {6'd0, 5'd9, 5'd10, 5'd11, 11'h020};
  localparam logic [31:0] BEQ1     = {6'b000100, 5'd1, 5'd2, 16'd3};
  localparam logic [31:0] BNE2     = {6'b000101, 5'd3, 5'd4, 16'd7};
  localparam logic [31:0] BEQ_RS8  = {6'b000100, 5'd8, 5'd0, 16'd2};

  always #5 clk = ~clk;

  hazard_stall_ctrl dut_a (
    .clk(clk), .reset_n(reset_n), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_instr(if_id_instr), .flush(flush), .hold_pc(a_hold_pc), .hold_if_id(a_hold_if_id),
    .bubble_sel(a_bubble), .stall_type(a_stype),
`ifdef HAZARD_PERF_CNT_EN
    .load_stall_cnt(a_ld_cnt), .branch_stall_cnt(a_br_cnt),
`endif
    .dbg_state(a_dbg)
  );

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(4), .BRANCH_STALL_CYCLES(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_instr(if_id_instr), .flush(flush), .hold_pc(b_hold_pc), .hold_if_id(b_hold_if_id),
    .bubble_sel(b_bubble), .stall_type(b_stype),
`ifdef HAZARD_PERF_CNT_EN
    .load_stall_cnt(b_ld_cnt), .branch_stall_cnt(b_br_cnt),
`endif
    .dbg_state(b_dbg)
  );

  task automatic step(input logic [31:0] instr, input logic mr, input logic [4:0] rt,
                      input logic fl, input logic rn, input logic [4:0] ea, input logic [4:0] eb);
    logic [9:0] e;
    logic [4:0] obs_a, obs_b;
    if_id_instr    = instr;
    id_ex_mem_read = mr;
    id_ex_rt       = rt;
    flush          = fl;
    reset_n        = rn;
    exp_q.push_back({ea, eb});
    step_no++;
    @(negedge clk);
    e     = exp_q.pop_front();
    obs_a = {a_hold_pc, a_hold_if_id, a_bubble, a_stype};
    obs_b = {b_hold_pc, b_hold_if_id, b_bubble, b_stype};
    total++;
    assert (obs_a === e[9:5]) else begin
      bad++;
      $error("FAIL step%0d dut_a observed=%b expected=%b", step_no, obs_a, e[9:5]);
    end
    total++;
    assert (obs_b === e[4:0]) else begin
      bad++;
      $error("FAIL step%0d dut_b observed=%b expected=%b", step_no, obs_b, e[4:0]);
    end
    if (!rn) begin
      exp_a_ld = 0; exp_a_br = 0; exp_b_ld = 0; exp_b_br = 0;
    end else begin
      if (e[6:5] == 2'b01) exp_a_ld++;
      if (e[6:5] == 2'b10) exp_a_br++;
      if (e[1:0] == 2'b01) exp_b_ld++;
      if (e[1:0] == 2'b10) exp_b_br++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; id_ex_mem_read = 1'b0; id_ex_rt = 5'd0; if_id_instr = NOP; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(NOP, 1'b0, 5'd0, 1'b0, 1'b0, NO, NO);       // reset state
    step(NOP, 1'b0, 5'd0, 1'b0, 1'b1, NO, NO);
    // load-use on rs: 1 cycle for A, 4 cycles for B
    step(ADD_RS8, 1'b1, 5'd8, 1'b0, 1'b1, LD, LD);
    step(NOP, 1'b0, 5'd0, 1'b0, 1'b1, NO, LD);
    step(NOP, 1'b0, 5'd0, 1'b0, 1'b1, NO, LD);
    step(NOP, 1'b0, 5'd0, 1'b0, 1'b1, NO, LD);
    step(NOP, 1'b0, 5'd0, 1'b0, 1'b1, NO, NO);
    // register 0 and non-matching registers
    step(NOP, 1'b1, 5'd0, 1'b0, 1'b1, NO, NO);
    step(ADD_NOM, 1'b1, 5'd8, 1'b0, 1'b1, NO, NO);
    // branch held in IF/ID: A stalls 2, B stalls 3, then one suppressed cycle
    step(BEQ1, 1'b0, 5'd0, 1'b0, 1'b1, BR, BR);
    step(BEQ1, 1'b0, 5'd0, 1'b0, 1'b1, BR, BR);
    step(BEQ1, 1'b0, 5'd0, 1'b0, 1'b1, NO, BR);
    step(NOP,  1'b0, 5'd0, 1'b0, 1'b1, NO, NO);
    // a following bne stalls normally
    step(BNE2, 1'b0, 5'd0, 1'b0, 1'b1, BR, BR);
    step(BNE2, 1'b0, 5'd0, 1'b0, 1'b1, BR, BR);
    step(BNE2, 1'b0, 5'd0, 1'b0, 1'b1, NO, BR);
    step(NOP,  1'b0, 5'd0, 1'b0, 1'b1, NO, NO);
    // load followed by dependent beq: load stall then branch stall, back to back
    step(BEQ_RS8, 1'b1, 5'd8, 1'b0, 1'b1, LD, LD);
    step(BEQ_RS8, 1'b0, 5'd0, 1'b0, 1'b1, BR, LD);
    step(BEQ_RS8, 1'b0, 5'd0, 1'b0, 1'b1, BR, LD);
    step(BEQ_RS8, 1'b0, 5'd0, 1'b0, 1'b1, NO, LD);
    step(BEQ_RS8, 1'b0, 5'd0, 1'b0, 1'b1, BR, BR);
    step(BEQ_RS8, 1'b0, 5'd0, 1'b0, 1'b1, BR, BR);
    step(NOP,     1'b0, 5'd0, 1'b0, 1'b1, NO, BR);
    step(NOP,     1'b0, 5'd0, 1'b0, 1'b1, NO, NO);
    // flush in the second cycle of a branch stall
    step(BEQ1, 1'b0, 5'd0, 1'b0, 1'b1, BR, BR);
    step(BEQ1, 1'b0, 5'd0, 1'b1, 1'b1, NO, NO);
    step(NOP,  1'b0, 5'd0, 1'b0, 1'b1, NO, NO);
    // reset mid-load stall
    step(ADD_RS8, 1'b1, 5'd8, 1'b0, 1'b1, LD, LD);
    step(NOP,     1'b0, 5'd0, 1'b0, 1'b0, NO, LD);
    step(NOP,     1'b0, 5'd0, 1'b0, 1'b1, NO, NO);
    step(NOP,     1'b0, 5'd0, 1'b0, 1'b1, NO, NO);
    step(NOP,     1'b0, 5'd0, 1'b0, 1'b1, NO, NO);
    // flush overrides a load hazard in IDLE
    step(ADD_RS8, 1'b1, 5'd8, 1'b1, 1'b1, NO, NO);
    step(NOP,     1'b0, 5'd0, 1'b0, 1'b1, NO, NO);
    // a fresh branch after flush/reset still stalls
    step(BNE2, 1'b0, 5'd0, 1'b0, 1'b1, BR, BR);
    step(BNE2, 1'b0, 5'd0, 1'b0, 1'b1, BR, BR);
    step(NOP,  1'b0, 5'd0, 1'b0, 1'b1, NO, BR);
    step(NOP,  1'b0, 5'd0, 1'b0, 1'b1, NO, NO);
`ifdef HAZARD_PERF_CNT_EN
    total++;
    assert (a_ld_cnt === 32'(exp_a_ld)) else begin
      bad++; $error("FAIL a_ld_cnt observed=%0d expected=%0d", a_ld_cnt, exp_a_ld);
    end
    total++;
    assert (a_br_cnt === 32'(exp_a_br)) else begin
      bad++; $error("FAIL a_br_cnt observed=%0d expected=%0d", a_br_cnt, exp_a_br);
    end
    total++;
    assert (b_ld_cnt === 32'(exp_b_ld)) else begin
      bad++; $error("FAIL b_ld_cnt observed=%0d expected=%0d", b_ld_cnt, exp_b_ld);
    end
    total++;
    assert (b_br_cnt === 32'(exp_b_br)) else begin
      bad++; $error("FAIL b_br_cnt observed=%0d expected=%0d", b_br_cnt, exp_b_br);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Parametrised successor to the single-cycle hazard detector for the pipelined MIPS core. It detects load-use and branch hazards on the instruction in IF/ID. It holds PC and IF/ID and selects the ID/EX bubble mux for a configurable number of cycles, using a counter-driven FSM. It sits beside the ID stage and drives the PC-write, IF/ID-write and control-zero mux selects.

Parameters:
REG_ADDR_W, 5, register-specifier width; rs at instr[25:21], rt at instr[20:16] for the default.
INSTR_W, 32, instruction width; opcode is instr[INSTR_W-1:INSTR_W-6].
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
BRANCH_STALL_CYCLES, 2, bubbles inserted per branch in ID (1..7).
OPC_BEQ, 6'b000100, branch-equal opcode.
OPC_BNE, 6'b000101, branch-not-equal opcode.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  synchronous active-low reset.
id_ex_mem_read  in  1  instruction in ID/EX is a load.
id_ex_rt  in  REG_ADDR_W  load destination register in ID/EX.
if_id_instr  in  INSTR_W  instruction held in IF/ID.
flush  in  1  pipeline flush from EX (taken branch or exception); aborts any stall.
hold_pc  out  1  1 = PC not written.
hold_if_id  out  1  1 = IF/ID not written.
bubble_sel  out  1  1 = ID/EX control zeroed (bubble).
stall_type  out  2  00 none, 01 load-use, 10 branch.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (reset_n), sampled on the rising edge of clk. While reset_n=0 at an edge, the next state is IDLE, cnt=0 and br_sup=0. All outputs are 0 whenever state=IDLE and no hazard is detected. Reset mid-stall drops all holds in the cycle after the reset edge.
- Load-use detection (combinational): ld_haz = id_ex_mem_read && id_ex_rt!=0 && (id_ex_rt==rs || id_ex_rt==rt). Register 0 never causes a hazard.
- Branch detection: br_haz = (opcode==OPC_BEQ || opcode==OPC_BNE) && !br_sup.
- FSM states are IDLE, LOAD, BRANCH; cnt is a 3-bit down-counter.
- IDLE:
  - If ld_haz: outputs assert in the same cycle (stall_type=01). If LOAD_STALL_CYCLES>1, next state is LOAD with cnt=LOAD_STALL_CYCLES-1.
  - Else if br_haz: outputs assert in the same cycle (stall_type=10). If BRANCH_STALL_CYCLES>1, next state is BRANCH with cnt=BRANCH_STALL_CYCLES-1; otherwise stay in IDLE and set br_sup.
  - Else: outputs are 0.
- LOAD / BRANCH:
  - All three holds are 1 and stall_type is held.
  - cnt decrements each cycle. In the cycle with cnt==1 the next state is IDLE.
  - Leaving BRANCH sets br_sup.
- Total stall length is exactly LOAD_STALL_CYCLES or BRANCH_STALL_CYCLES cycles.
- br_sup is set on the final branch-stall cycle and cleared at the end of the next cycle in which hold_if_id=0. The same branch is therefore never re-stalled, while the following branch stalls normally.
- Priority: ld_haz over br_haz. A branch that depends on a load gets the load stall first. In the following cycle ID/EX holds a bubble, so the branch stall then starts; the two stalls are back-to-back with no gap.
- flush=1 has highest priority: outputs are forced to 0 that cycle, and the next state is IDLE with cnt=0 and br_sup=0.
- Hazards are not evaluated while in LOAD or BRANCH; the counter alone ends the stall.

Optional Feature:
HAZARD_PERF_CNT_EN:
- When defined, adds outputs load_stall_cnt[31:0] and branch_stall_cnt[31:0].
- Each counter increments on every clock edge where the corresponding stall_type is active and flush=0.
- Both counters saturate at 0xFFFFFFFF and are cleared by reset.
- When undefined, these ports and their logic are absent and the rest of the behaviour is unchanged.

Test Plan:
- Load-use on rs: id_ex_mem_read=1, id_ex_rt=8, instr rs=8 (add $9,$8,$10), defaults -> holds=1, stall_type=01 for exactly 1 cycle, then 0.
- Register-0 and no-match: id_ex_rt=0 with rs=0, and id_ex_rt=8 with rs=9/rt=10 -> no stall.
- Branch, BRANCH_STALL_CYCLES=3: instr opcode 000100 held in IF/ID -> holds=1 for exactly 3 cycles, stall_type=10, then 0 for 1 cycle with the same instr (br_sup). A new beq after IF/ID advances stalls again.
- Load followed by dependent beq: ld_haz and the branch in the same cycle -> 1 cycle of 01 followed immediately by 2 cycles of 10, 3 hold cycles total.
- flush=1 in the 2nd cycle of a 3-cycle branch stall -> outputs 0 that cycle, state IDLE. With the macro defined, branch_stall_cnt shows +1.
- reset_n=0 mid-LOAD stall with LOAD_STALL_CYCLES=4 -> outputs 0 after the edge, and no residual stall after reset_n returns to 1.
